// File: rtl/io_shift_buffer.sv
// Bidirectional narrow<->wide shift buffer: deserialises FACTOR chunks into a word, or serialises a word into chunks.
// Optional macro IO_SHIFT_BUFFER_CHAINED_EN removes the idle cycle between back-to-back words.
module io_shift_buffer #(
  parameter  int DATA_W = 32,
  parameter  int REG_W  = 256,
  localparam int FACTOR = REG_W / DATA_W,
  localparam int CNT_W  = $clog2(FACTOR + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [REG_W-1:0]  reg_data,
  output logic              reg_valid,
  input  logic              reg_ready,
  input  logic [REG_W-1:0]  par_data,
  input  logic              par_valid,
  output logic              par_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  generate
    if ((REG_W % DATA_W) != 0 || FACTOR < 2) begin : g_bad_params
      $error("io_shift_buffer: REG_W must be a multiple of DATA_W with at least two chunks");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FACTOR);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [REG_W-1:0]   reg_q, reg_d;

  logic               in_fire, par_fire, reg_fire, out_fire;
  logic [REG_W-1:0]   shift_in, shift_out;

  // Chunks enter at the bottom and move up, so the first chunk ends in the top slice;
  // draining from the top slice therefore reproduces the original word on a round trip.
  assign shift_in  = {reg_q[REG_W-DATA_W-1:0], in_data};
  assign shift_out = {reg_q[REG_W-DATA_W-1:0], {DATA_W{1'b0}}};

  assign in_fire  = in_valid  & in_ready;
  assign par_fire = par_valid & par_ready;
  assign reg_fire = reg_valid & reg_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      reg_q   <= reg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    reg_d   = reg_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          reg_d   = shift_in;
          count_d = CNT_ONE;
          state_d = FILL;
        end else if (par_fire) begin
          reg_d   = par_data;
          count_d = CNT_FULL;
          state_d = DRAIN;
        end
      end
      FILL: begin
        if (in_fire) begin
          reg_d   = shift_in;
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_FULL - CNT_ONE) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (reg_fire) begin
          count_d = '0;
          state_d = IDLE;
`ifdef IO_SHIFT_BUFFER_CHAINED_EN
          if (in_fire) begin
            reg_d   = shift_in;
            count_d = CNT_ONE;
            state_d = FILL;
          end
`endif
        end
      end
      DRAIN: begin
        if (out_fire) begin
          reg_d   = shift_out;
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d = IDLE;
          end
`ifdef IO_SHIFT_BUFFER_CHAINED_EN
          if (par_fire) begin
            reg_d   = par_data;
            count_d = CNT_FULL;
            state_d = DRAIN;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    par_ready = 1'b0;
    reg_valid = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready  = ~mode;
        par_ready = mode;
      end
      FILL: begin
        in_ready = 1'b1;
      end
      FULL: begin
        reg_valid = 1'b1;
`ifdef IO_SHIFT_BUFFER_CHAINED_EN
        in_ready  = reg_ready;
`endif
      end
      DRAIN: begin
        out_valid = 1'b1;
`ifdef IO_SHIFT_BUFFER_CHAINED_EN
        par_ready = (count_q == CNT_ONE) & out_ready;
`endif
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign count    = count_q;
  assign reg_data = reg_q;
  assign out_data = reg_q[REG_W-DATA_W +: DATA_W];

endmodule

// File: tb/tb_io_shift_buffer.sv
// Directed bench for io_shift_buffer (DATA_W=32, REG_W=128) with queue-based scoreboards.
module tb_io_shift_buffer;
  localparam int DW = 32;
  localparam int RW = 128;
  localparam int F  = RW / DW;
  localparam int CW = $clog2(F + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] reg_data;
  logic          reg_valid;
  logic          reg_ready;
  logic [RW-1:0] par_data;
  logic          par_valid;
  logic          par_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          busy;

  io_shift_buffer #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reg_data(reg_data), .reg_valid(reg_valid), .reg_ready(reg_ready),
    .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] wq[$];
  logic [DW-1:0] cq[$];
  logic [DW-1:0] rt[$];

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [RW-1:0] w, input logic [RW-1:0] expect_w, input bit toggle);
    logic f;
    int n;
    wq.push_back(expect_w);
    mode = 1'b0;
    for (int i = 0; i < F; i++) begin
      in_data  = w[RW-1-DW*i -: DW];
      in_valid = 1'b1;
      n = 0;
      do begin
        #1 f = in_ready;
        cyc();
        n++;
      end while (!f && n < 50);
      if (!f) chk("in_handshake", RW'(f), RW'(1));
      if (toggle && i == 1) mode = 1'b1;
    end
    in_valid = 1'b0;
    mode     = 1'b0;
    chk("full_reg_valid", RW'(reg_valid), RW'(1));
    chk("full_count", RW'(count), RW'(F));
  endtask

  task automatic recv_word();
    int n = 0;
    while (!reg_valid && n < 50) begin
      cyc();
      n++;
    end
    chk("reg_valid_wait", RW'(reg_valid), RW'(1));
    if (wq.size() == 0) chk("word_queue_empty", RW'(wq.size()), RW'(1));
    else chk("reg_data", reg_data, wq.pop_front());
    cyc();
    chk("full_hold_in_ready", RW'(in_ready), RW'(0));
    chk("full_hold_valid", RW'(reg_valid), RW'(1));
    reg_ready = 1'b1;
    cyc();
    reg_ready = 1'b0;
    chk("idle_after_handoff", RW'({busy, count}), RW'(0));
  endtask

  task automatic send_par(input logic [RW-1:0] w);
    logic f;
    int n = 0;
    mode = 1'b1;
    for (int i = 0; i < F; i++) cq.push_back(w[RW-1-DW*i -: DW]);
    par_data  = w;
    par_valid = 1'b1;
    do begin
      #1 f = par_ready;
      cyc();
      n++;
    end while (!f && n < 50);
    par_valid = 1'b0;
    chk("par_handshake", RW'(f), RW'(1));
    chk("drain_count", RW'(count), RW'(F));
  endtask

  task automatic recv_chunks(input logic [7:0] pat);
    int got = 0;
    int k = 0;
    logic stall;
    logic [DW-1:0] hd;
    logic [CW-1:0] hc;
    while (got < F && k < 40) begin
      out_ready = pat[k % 8];
      #1;
      stall = 1'b0;
      if (out_valid && out_ready) begin
        if (cq.size() == 0) chk("chunk_queue_empty", RW'(cq.size()), RW'(1));
        else chk("out_data", RW'(out_data), RW'(cq.pop_front()));
        rt.push_back(out_data);
        got++;
      end else if (out_valid) begin
        stall = 1'b1;
        hd = out_data;
        hc = count;
      end
      cyc();
      if (stall) begin
        chk("stall_out_data", RW'(out_data), RW'(hd));
        chk("stall_count", RW'(count), RW'(hc));
      end
      k++;
    end
    out_ready = 1'b0;
    mode      = 1'b0;
    chk("chunks_received", RW'(got), RW'(F));
    chk("idle_after_drain", RW'({busy, out_valid}), RW'(0));
  endtask

  initial begin
    logic [RW-1:0] w, w2;
    rst = 1'b0; mode = 1'b0; in_data = '0; in_valid = 1'b0; reg_ready = 1'b0;
    par_data = '0; par_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_reg_data", reg_data, '0);
    chk("rst_flags", RW'({reg_valid, out_valid, busy, in_ready, par_ready}), RW'(5'b00010));
    chk("rst_out_count", RW'({out_data, count}), RW'(0));
    mode = 1'b1;
    #1;
    chk("rst_mode1_ready", RW'({in_ready, par_ready}), RW'(2'b01));
    mode = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    send_word(128'h0000000A_0000000B_0000000C_0000000D, 128'h0000000A_0000000B_0000000C_0000000D, 1'b0);
    recv_word();

    send_par(128'h11111111_22222222_33333333_44444444);
    recv_chunks(8'hFF);
    rt.delete();

    send_par(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    recv_chunks(8'b1111_1001);
    rt.delete();

    mode = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h55555555;
    cyc();
    in_data = 32'h66666666;
    cyc();
    in_valid = 1'b0;
    chk("partial_count", RW'(count), RW'(2));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", RW'(count), RW'(0));
    chk("async_rst_reg_data", reg_data, '0);
    chk("async_rst_flags", RW'({reg_valid, busy}), RW'(0));
    #1 rst = 1'b1;
    cyc();
    send_word(128'h01010101_02020202_03030303_04040404, 128'h01010101_02020202_03030303_04040404, 1'b0);
    recv_word();

    for (int j = 0; j < 100; j++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      send_par(w);
      recv_chunks(8'hFF);
      w2 = '0;
      for (int i = 0; i < F; i++) begin
        if (rt.size() != 0) w2[RW-1-DW*i -: DW] = rt.pop_front();
      end
      rt.delete();
      send_word(w2, w, j[0]);
      recv_word();
    end

`ifdef IO_SHIFT_BUFFER_CHAINED_EN
    begin
      logic [RW-1:0] sw [3];
      int words = 0;
      int last  = -1;
      for (int i = 0; i < 3; i++) begin
        sw[i] = {$urandom, $urandom, $urandom, $urandom};
        wq.push_back(sw[i]);
      end
      mode = 1'b0;
      reg_ready = 1'b1;
      for (int j = 0; j <= 3 * F; j++) begin
        in_valid = (j < 3 * F);
        if (j < 3 * F) in_data = sw[j / F][RW-1-DW*(j % F) -: DW];
        #1;
        if (j < 3 * F) chk("chain_in_ready", RW'(in_ready), RW'(1));
        if (reg_valid) begin
          if (wq.size() != 0) chk("chain_reg_data", reg_data, wq.pop_front());
          if (last >= 0) chk("chain_word_spacing", RW'(j - last), RW'(F));
          last = j;
          words++;
        end
        cyc();
      end
      in_valid = 1'b0;
      reg_ready = 1'b0;
      chk("chain_words", RW'(words), RW'(3));
    end
    begin
      logic [RW-1:0] pw [2];
      int pidx = 0;
      logic pf;
      for (int i = 0; i < 2; i++) begin
        pw[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < F; c++) cq.push_back(pw[i][RW-1-DW*c -: DW]);
      end
      mode = 1'b1;
      out_ready = 1'b1;
      for (int j = 0; j <= 2 * F; j++) begin
        par_valid = (pidx < 2);
        par_data  = pw[pidx < 2 ? pidx : 1];
        #1;
        pf = par_valid & par_ready;
        if (j >= 1) chk("chain_out_valid", RW'(out_valid), RW'(1));
        if (out_valid && cq.size() != 0) chk("chain_out_data", RW'(out_data), RW'(cq.pop_front()));
        cyc();
        if (pf) pidx++;
      end
      par_valid = 1'b0;
      out_ready = 1'b0;
      mode = 1'b0;
      chk("chain_drain_done", RW'({busy, pidx[1:0]}), RW'(3'b010));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_shift_buffer.md
Name: io_shift_buffer

Overview:
- Parametrised, bidirectional successor to the periphery input shift register.
- Mode 0 (deserialise): collects FACTOR narrow chunks into one wide register word and hands it to the core with a valid/ready handshake.
- Mode 1 (serialise): loads a wide word from the core and streams it out as narrow chunks with a valid/ready handshake.
- Sits between the chip I/O pads and the core-side wide registers.

Parameters:
- DATA_W, 32, narrow I/O chunk width in bits.
- REG_W, 256, wide register width in bits. REG_W % DATA_W must be 0.
- FACTOR, REG_W/DATA_W (derived localparam), chunks per word. Must be >= 2.
- CNT_W, $clog2(FACTOR+1) (derived localparam), chunk counter width.
- Elaboration fails if REG_W % DATA_W != 0 or FACTOR < 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = deserialise, 1 = serialise. Sampled only in IDLE.
- in_data  in  DATA_W  narrow input chunk.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- reg_data  out  REG_W  wide register contents, driven directly from the internal register.
- reg_valid  out  1  reg_data holds a complete deserialised word.
- reg_ready  in  1  core consumes reg_data.
- par_data  in  REG_W  wide word to serialise.
- par_valid  in  1  par_data is valid.
- par_ready  out  1  block accepts par_data this cycle.
- out_data  out  DATA_W  narrow output chunk.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream consumes out_data.
- count  out  CNT_W  chunks currently held.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst = 0): reg_q = 0, count = 0, state = IDLE. Reset applied mid-word drops the partial word silently.
- Reset values of outputs: reg_valid = 0, out_valid = 0, busy = 0, in_ready = ~mode, par_ready = mode, reg_data = 0, out_data = 0.
- State machine: IDLE, FILL, FULL, DRAIN. Handshake outputs are decoded combinationally from state (and mode in IDLE).
- A transfer occurs when valid & ready are both 1 on a rising edge.
- IDLE:
  - in_ready = ~mode, par_ready = mode.
  - mode = 0 and in_valid: shift in chunk, count = 1, go FILL.
  - mode = 1 and par_valid: reg_q = par_data, count = FACTOR, go DRAIN.
  - Only one path is possible per cycle because mode selects it.
- Shift-in rule (FILL and IDLE):
  - reg_q[0 +: DATA_W] <= in_data.
  - Slice i <= slice i-1 for i = 1..FACTOR-1.
  - After FACTOR transfers, the first chunk sits in the top slice.
- FILL:
  - in_ready = 1.
  - On each transfer, count++.
  - When the transfer brings count to FACTOR, go FULL.
  - No transfer: hold.
- FULL:
  - reg_valid = 1, in_ready = 0, reg_q frozen.
  - On reg_ready: count = 0, go IDLE, giving one idle cycle between words.
- DRAIN:
  - out_valid = 1, out_data = reg_q[REG_W-DATA_W +: DATA_W], i.e. top slice first.
  - On transfer: reg_q <<= DATA_W (zero-fill bottom), count--.
  - When count goes 1 -> 0, go IDLE.
  - out_ready held low: out_data and reg_q stable.
- Ordering contract: a serialised word, when deserialised, reproduces the original word bit-exactly (round trip).
- Changes on mode outside IDLE are ignored. Inputs whose ready is 0 are ignored.
- count never exceeds FACTOR and never underflows.

Optional Feature:
- Macro: IO_SHIFT_BUFFER_CHAINED_EN.
- Defined:
  - In FULL, in_ready = reg_ready.
  - A simultaneous reg handoff and in transfer loads the new chunk into slice 0 (upper slices don't care), sets count = 1, goes FILL.
  - In DRAIN, par_ready = (count == 1) & out_ready; a simultaneous last-chunk transfer and par transfer loads par_data, sets count = FACTOR, stays DRAIN.
  - Result: zero-bubble back-to-back words.
- Undefined: behaviour exactly as above, with one IDLE cycle between words.

Test Plan:
- Deserialise, DATA_W=32, REG_W=128: chunks 0xA,0xB,0xC,0xD with in_valid held high -> reg_valid at cycle 4, reg_data = {A,B,C,D} (A at bits 127:96), in_ready = 0 until reg_ready.
- Serialise: par_data = 0x11111111_22222222_33333333_44444444 -> out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on successive out_ready cycles, then busy = 0.
- Backpressure: out_ready toggling 1,0,0,1 in DRAIN -> out_data/count stable while low; no chunk lost or duplicated.
- Async reset asserted after 2 of 4 chunks -> count = 0, reg_data = 0, reg_valid = 0 immediately; next 4 chunks yield a clean word.
- Round trip plus mode change mid-FILL: mode toggled during FILL is ignored; deser(ser(random word)) equals the word over 100 random words. With IO_SHIFT_BUFFER_CHAINED_EN, continuous streaming gives one word per FACTOR cycles.
